// File: rtl/zero_regfile_pkg.sv
// Shared constants and helpers for the zero_regfile register file.
// Optional write bypass is selected by the macro ZERO_REGFILE_WR_BYPASS_EN.
package zero_regfile_pkg;

  localparam int DEF_SIZE   = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_RD = 2;

  // Architectural zero register address
  localparam int ZERO_ADDR = 0;

  // Low bit of port p's field in a packed multi-port bus of the given field width
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/zero_regfile_if.sv
// Write/read bus of the zero_regfile: one write port, NUM_RD packed read ports.
interface zero_regfile_if #(
  parameter int SIZE   = zero_regfile_pkg::DEF_SIZE,
  parameter int DEPTH  = zero_regfile_pkg::DEF_DEPTH,
  parameter int NUM_RD = zero_regfile_pkg::DEF_NUM_RD
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     wr_en_i;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [SIZE-1:0]          din_i;
  logic [NUM_RD-1:0]        rd_en_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*SIZE-1:0]   dout_o;
  logic [NUM_RD-1:0]        rd_vld_o;

  modport master (
    output wr_en_i, wr_addr_i, din_i, rd_en_i, rd_addr_i,
    input  dout_o, rd_vld_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, din_i, rd_en_i, rd_addr_i,
    output dout_o, rd_vld_o
  );
endinterface

// File: rtl/zero_regfile_rdport.sv
// One registered read port: zero-address forcing, optional write bypass, hold and valid.
// Bypass is enabled by the macro ZERO_REGFILE_WR_BYPASS_EN.
module zero_regfile_rdport
  import zero_regfile_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE-1:0]   wr_data,
  input  logic [SIZE-1:0]   entry,
  output logic [SIZE-1:0]   dout,
  output logic              vld
);

`ifdef ZERO_REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            is_zero;
  logic            wr_hit;
  logic [SIZE-1:0] rd_next;

  assign is_zero = (rd_addr == ADDR_W'(ZERO_ADDR));
  assign wr_hit  = BYPASS && wr_en && (wr_addr == rd_addr);

  // Address 0 wins over the bypass so the zero register never sees write data
  assign rd_next = is_zero ? '0 : (wr_hit ? wr_data : entry);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= rd_en;
      if (rd_en) dout <= rd_next;
    end
  end

endmodule

// File: rtl/zero_regfile.sv
// Register file with entry 0 hardwired to zero, one write port and NUM_RD registered read ports.
// Build option: ZERO_REGFILE_WR_BYPASS_EN selects write-before-read on same-address access.
module zero_regfile
  import zero_regfile_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  zero_regfile_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Entry 0 has no storage; the array starts at 1
  logic [SIZE-1:0] mem [1:DEPTH-1];
  logic [SIZE-1:0] rd_entry [NUM_RD];
  logic [SIZE-1:0] dout_q [NUM_RD];
  logic [NUM_RD-1:0] vld_q;

  // NOTE: the storage is reset explicitly because the CPU relies on a known all-zero file after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.wr_en_i && (bus.wr_addr_i == ADDR_W'(i))) mem[i] <= bus.din_i;
      end
    end
  end

  // NOTE: each read result gets a default before the decode so no latch is inferred.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_entry[p] = '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(i)) rd_entry[p] = mem[i];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    zero_regfile_rdport #(
      .SIZE   (SIZE),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .rd_en   (bus.rd_en_i[p]),
      .rd_addr (bus.rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W]),
      .wr_en   (bus.wr_en_i),
      .wr_addr (bus.wr_addr_i),
      .wr_data (bus.din_i),
      .entry   (rd_entry[p]),
      .dout    (dout_q[p]),
      .vld     (vld_q[p])
    );

    assign bus.dout_o[slice_lo(p, SIZE) +: SIZE] = dout_q[p];
  end

  assign bus.rd_vld_o = vld_q;

endmodule

// File: tb/tb_zero_regfile.sv
// Self-checking bench for zero_regfile: directed plan steps then random traffic against an array model.
// Honors ZERO_REGFILE_WR_BYPASS_EN to pick the expected same-cycle read/write result.
module tb_zero_regfile;

  localparam int SIZE   = 8;
  localparam int DEPTH  = 8;
  localparam int NUM_RD = 2;
  localparam int AW     = $clog2(DEPTH);

`ifdef ZERO_REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;

  zero_regfile_if #(.SIZE(SIZE), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

  zero_regfile #(.SIZE(SIZE), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: plain array of register contents plus expected port outputs
  logic [SIZE-1:0] model [DEPTH];
  logic [SIZE-1:0] exp_dout [NUM_RD];
  logic            exp_vld  [NUM_RD];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] dout_of(input int p);
    return bus.dout_o[p*SIZE +: SIZE];
  endfunction

  task automatic idle();
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = '0;
    bus.din_i     = '0;
    bus.rd_en_i   = '0;
    bus.rd_addr_i = '0;
  endtask

  task automatic set_rd(input int p, input bit en, input int a);
    bus.rd_en_i[p] = en;
    bus.rd_addr_i[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input bit en, input int a, input logic [SIZE-1:0] d);
    bus.wr_en_i   = en;
    bus.wr_addr_i = AW'(a);
    bus.din_i     = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      exp_dout[p] = '0;
      exp_vld[p]  = 1'b0;
    end
  endtask

  // One clock: update the model from the driven inputs, then compare all port outputs
  task automatic step(input string tag);
    int a;
    @(posedge clk_i);
    for (int p = 0; p < NUM_RD; p++) begin
      exp_vld[p] = bus.rd_en_i[p];
      if (bus.rd_en_i[p]) begin
        a = int'(bus.rd_addr_i[p*AW +: AW]);
        if (a == 0)
          exp_dout[p] = '0;
        else if (BYP && bus.wr_en_i && int'(bus.wr_addr_i) == a)
          exp_dout[p] = bus.din_i;
        else
          exp_dout[p] = model[a];
      end
    end
    if (bus.wr_en_i && bus.wr_addr_i != '0) model[bus.wr_addr_i] = bus.din_i;
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      check($sformatf("%s_dout%0d", tag, p), 32'(dout_of(p)), 32'(exp_dout[p]));
      check($sformatf("%s_vld%0d", tag, p), 32'(bus.rd_vld_o[p]), 32'(exp_vld[p]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    model_reset();
    #12;
    check("rst_dout", 32'(bus.dout_o), 32'h0);
    check("rst_vld", 32'(bus.rd_vld_o), 32'h0);
    rst_n_i = 1'b1;
    #10;

    // Every address reads back zero after reset on both ports
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, 1'b1, a);
      set_rd(1, 1'b1, a);
      step("rst_rd");
      check("rst_rd_lit", 32'(bus.dout_o), 32'h0);
    end
    idle();
    step("vld_drop");
    check("vld_drop_lit", 32'(bus.rd_vld_o), 32'h0);

    // Write A5 to 3, then read 3 on port 0 and 0 on port 1
    set_wr(1'b1, 3, 8'hA5);
    step("wr3");
    idle();
    set_rd(0, 1'b1, 3);
    set_rd(1, 1'b1, 0);
    step("rd3");
    check("rd3_p0_lit", 32'(dout_of(0)), 32'hA5);
    check("rd3_p1_lit", 32'(dout_of(1)), 32'h00);

    // Writes to the zero register are discarded
    idle();
    set_wr(1'b1, 0, 8'hFF);
    step("wr0");
    idle();
    set_rd(0, 1'b1, 0);
    set_rd(1, 1'b1, 0);
    step("rd0");
    check("rd0_lit", 32'(bus.dout_o), 32'h0);

    // Same-cycle read and write of one address
    idle();
    set_wr(1'b1, 5, 8'h11);
    step("wr5a");
    set_wr(1'b1, 5, 8'h22);
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b0, 0);
    step("rw5");
    check("rw5_lit", 32'(dout_of(0)), BYP ? 32'h22 : 32'h11);
    idle();
    set_rd(0, 1'b1, 5);
    step("rd5");
    check("rd5_lit", 32'(dout_of(0)), 32'h22);

    // Hold: read 3 then keep rd_en low while 3 is overwritten
    idle();
    set_rd(0, 1'b1, 3);
    step("hold_rd");
    idle();
    set_wr(1'b1, 3, 8'h5A);
    for (int k = 0; k < 3; k++) begin
      step("hold");
      check("hold_lit", 32'(dout_of(0)), 32'hA5);
      check("hold_vld_lit", 32'(bus.rd_vld_o), 32'h0);
    end

    // Mid-cycle async reset with a write to 2 pending
    idle();
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 3);
    step("pre_rst");
    idle();
    set_wr(1'b1, 2, 8'h77);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("async_dout", 32'(bus.dout_o), 32'h0);
    check("async_vld", 32'(bus.rd_vld_o), 32'h0);
    model_reset();
    @(posedge clk_i);
    #5;
    rst_n_i = 1'b1;
    idle();
    set_rd(0, 1'b1, 2);
    set_rd(1, 1'b1, 5);
    step("post_rst");
    check("post_rst_lit", 32'(bus.dout_o), 32'h0);

    // Random traffic, including address 0 and port collisions
    for (int n = 0; n < 400; n++) begin
      set_wr(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), SIZE'($urandom));
      for (int p = 0; p < NUM_RD; p++)
        set_rd(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zero_regfile.md
Name: zero_regfile

Overview:
- Parametrised register file; entry 0 is hardwired zero: writes to it are discarded and reads return 0.
- NUM_RD independent registered read ports and one write port.
- Successor to the single-entry zero register; serves as the CPU integer register file, entry 0 being the architectural zero register.

Parameters:
- SIZE, 8, data width in bits (>=1).
- DEPTH, 8, number of entries including entry 0 (power of 2, >=2).
- NUM_RD, 2, number of read ports (1..4).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- wr_en_i  in  1  write enable.
- wr_addr_i  in  ADDR_W  write address.
- din_i  in  SIZE  write data.
- rd_en_i  in  NUM_RD  per-port read enable.
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- dout_o  out  NUM_RD*SIZE  packed registered read data; port p uses bits [p*SIZE +: SIZE].
- rd_vld_o  out  NUM_RD  per-port valid, high the cycle after an accepted read.

Behaviour:
- Reset, asynchronous on rst_n_i low:
  - entries 1..DEPTH-1 = 0
  - dout_o = 0
  - rd_vld_o = 0
  - Takes effect immediately and overrides any write or read in flight. The first edge after deassertion behaves normally.
- Write, when wr_en_i=1 at a rising edge:
  - wr_addr_i != 0: entry[wr_addr_i] <= din_i.
  - wr_addr_i == 0: no state change. No error is flagged.
- Read, per port p, independent of the other ports:
  - rd_en_i[p]=1 at edge N: dout_o[p] holds the entry value from edge N+1 onward, and rd_vld_o[p]=1 for that one cycle. Latency is 1 cycle.
  - rd_en_i[p]=0: dout_o[p] holds its previous value and rd_vld_o[p]=0.
  - rd_addr==0: dout_o[p] is 0 regardless of any write.
- Simultaneous read and write to the same nonzero address in the same cycle: governed by WR_BYPASS_EN (see Optional Feature).
- Several ports reading the same address in the same cycle all return the identical value.
- Entry 0 is not implemented as storage. No flop exists for it, and it has no reset dependence.
- Addresses are always in range because DEPTH is a power of 2.

Optional Feature:
- Macro: ZERO_REGFILE_WR_BYPASS_EN.
- Defined: a read at edge N whose address equals wr_addr_i, with wr_en_i=1 and address nonzero, captures din_i. This gives write-before-read semantics.
- Undefined: the same read captures the entry's old (pre-write) value, giving read-before-write semantics. The new value is visible to reads from edge N+1.
- Address 0 returns 0 in both builds.

Decomposition:
- Package zero_regfile_pkg holds:
  - the ZERO_ADDR localparam (0);
  - a function for the packed-slice index of port p;
  - the default SIZE/DEPTH/NUM_RD constants.
- Sub-module zero_regfile_rdport: one instance per read port, generated NUM_RD times. It contains:
  - the address compare and bypass mux;
  - the output register, hold logic and valid flop.

Test Plan (SIZE=8, DEPTH=8, NUM_RD=2):
- Reset, then read all addresses on both ports -> every dout_o = 0x00, and rd_vld_o pulses one cycle after each read.
- Write 0xA5 to addr 3, then read addr 3 on port 0 and addr 0 on port 1 in the next cycle -> port0 = 0xA5, port1 = 0x00.
- Write 0xFF to addr 0, then read addr 0 on both ports -> 0x00 on both.
- Addr 5 holds 0x11; write 0x22 to addr 5 while reading addr 5 in the same cycle -> 0x22 with the macro defined, 0x11 without it; the next read returns 0x22 in both builds.
- Read addr 3 (0xA5), then deassert rd_en_i for 3 cycles while writing addr 3 = 0x5A -> dout_o stays 0xA5 and rd_vld_o = 0 throughout.
- Assert rst_n_i low mid-cycle while a write to addr 2 is pending -> dout_o and rd_vld_o clear at once; after release, a read of addr 2 returns 0x00.
